// File: rtl/dlp_pack.sv
// dlp_pack: host-side display-list encoder.
// Collects host register writes into groups of up to three and emits each group as a fixed
// 4-word DLP entry over a valid/ready stream: one header word, then three data words.
//
// Ports:
//   hb_clk    - host bus clock, all logic on the rising edge
//   hb_rst    - synchronous active-high reset
//   reg_we    - register write request; accepted when reg_we & reg_rdy
//   reg_addr  - dword register address [8:2]
//   reg_data  - register write data
//   reg_rdy   - high in IDLE and COLLECT, low while an entry is emitted
//   flush     - close the current group now (or emit a NOP entry if a vsync wait is pending)
//   wvs_req   - pulse; the next emitted entry carries the wait-for-vsync bit
//   out_data  - entry word, 0 while no entry is being emitted
//   out_valid - out_data valid
//   out_ready - sink accepts the word when out_valid & out_ready
//   busy      - not idle, or a vsync wait is pending
//
// Configuration macro: DLP_PACK_COALESCE_EN - when defined, a write to an address already held
// in the open group overwrites that slot's data instead of taking a new slot.

module dlp_pack #(
    parameter logic [7:0] TIMEOUT  = 8'd255,
    parameter logic [6:0] NOP_ADDR = 7'h00
) (
    input  logic        hb_clk,
    input  logic        hb_rst,
    input  logic        reg_we,
    input  logic [6:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic        reg_rdy,
    input  logic        flush,
    input  logic        wvs_req,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StEmit
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [6:0]  addr_q [3];
    logic [6:0]  addr_d [3];
    logic [31:0] data_q [3];
    logic [31:0] data_d [3];
    logic        wvs_q, wvs_d;
    // Snapshot of the wvs bit placed in the header, so the header stays stable under
    // backpressure and a request arriving mid-entry is not lost.
    logic        hdr_wvs_q, hdr_wvs_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [1:0]  idx_q, idx_d;

    logic        wr_acc;
    logic        tmo_hit;
    logic        hdr_acc;
    logic        hit;
    logic [1:0]  new_count;

    logic [6:0]  addr_eff [3];
    logic [31:0] data_eff [3];
    logic [1:0]  wcount;
    logic [31:0] header;

    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            state_q   <= StIdle;
            count_q   <= 2'd0;
            wvs_q     <= 1'b0;
            hdr_wvs_q <= 1'b0;
            tmo_q     <= 8'd0;
            idx_q     <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                addr_q[i] <= 7'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wvs_q     <= wvs_d;
            hdr_wvs_q <= hdr_wvs_d;
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            for (int i = 0; i < 3; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hdr_wvs_d = hdr_wvs_q;
        tmo_d     = tmo_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        hit       = 1'b0;
        new_count = count_q;

        wr_acc  = reg_we && (state_q != StEmit);
        tmo_hit = (TIMEOUT != 8'd0) && (tmo_q == TIMEOUT);
        hdr_acc = (state_q == StEmit) && (idx_q == 2'd0) && out_ready;

        // Clear only the request that actually went out in the header.
        wvs_d = wvs_req | (wvs_q & ~(hdr_acc & hdr_wvs_q));

        unique case (state_q)
            StIdle: begin
                tmo_d = 8'd0;
                if (wr_acc) begin
                    addr_d[0] = reg_addr;
                    data_d[0] = reg_data;
                    count_d   = 2'd1;
                    state_d   = flush ? StEmit : StCollect;
                end else if (flush && wvs_q) begin
                    // count stays 0: the output mux turns this into a NOP entry
                    state_d = StEmit;
                end
            end
            StCollect: begin
                tmo_d = tmo_q + 8'd1;
                if (wr_acc) begin
                    tmo_d = 8'd0;
`ifdef DLP_PACK_COALESCE_EN
                    for (int i = 0; i < 3; i++) begin
                        if ((2'(i) < count_q) && (addr_q[i] == reg_addr)) begin
                            hit       = 1'b1;
                            data_d[i] = reg_data;
                        end
                    end
`endif
                    if (!hit) begin
                        for (int i = 0; i < 3; i++) begin
                            if (2'(i) == count_q) begin
                                addr_d[i] = reg_addr;
                                data_d[i] = reg_data;
                            end
                        end
                        new_count = count_q + 2'd1;
                    end
                end
                count_d = new_count;
                if ((new_count == 2'd3) || flush || tmo_hit) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                tmo_d = 8'd0;
                if (out_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        count_d = 2'd0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_d == StEmit) && (state_q != StEmit)) begin
            hdr_wvs_d = wvs_d;
        end
    end

    // Entry assembly: slots beyond count read as zero; an empty group is a NOP entry.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            addr_eff[i] = (2'(i) < count_q) ? addr_q[i] : 7'd0;
            data_eff[i] = (2'(i) < count_q) ? data_q[i] : 32'd0;
        end
        if (count_q == 2'd0) begin
            addr_eff[0] = NOP_ADDR;
        end
        wcount = (count_q == 2'd0) ? 2'd1 : count_q;
        header = {hdr_wvs_q, addr_eff[2][6], addr_eff[1][6], addr_eff[0][6], wcount, 2'b00,
                  addr_eff[2][5:0], 2'b00, addr_eff[1][5:0], 2'b00, addr_eff[0][5:0], 2'b00};
    end

    always_comb begin
        out_valid = (state_q == StEmit);
        reg_rdy   = (state_q != StEmit);
        busy      = (state_q != StIdle) || wvs_q;
        out_data  = 32'd0;
        if (state_q == StEmit) begin
            unique case (idx_q)
                2'd0:    out_data = header;
                2'd1:    out_data = data_eff[0];
                2'd2:    out_data = data_eff[1];
                default: out_data = data_eff[2];
            endcase
        end
    end

endmodule
